// File: rtl/ballot_unit.sv
// Ballot front end: synchronizes and debounces three candidate buttons and
// allows one accepted vote per issued ballot, freezing everything once polling closes.
module ballot_unit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_btn_1,
  input  logic        i_btn_2,
  input  logic        i_btn_3,
  input  logic        i_ballot,
  input  logic        i_voting_over,
  output logic        o_vote_1,
  output logic        o_vote_2,
  output logic        o_vote_3,
  output logic        o_reject,
  output logic        o_ready,
  output logic        o_closed,
  output logic [31:0] o_votes_cast
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    VOTED  = 3'd2,
    REJECT = 3'd3,
    CLOSED = 3'd4
  } state_t;

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

  logic [2:0] btn;
  logic [2:0] sync_a;
  logic [2:0] sync_b;
  logic [2:0] db;
  logic [2:0] db_prev;
  logic [7:0] cnt [3];
  logic [2:0] press;
  logic       multi;
  logic       single_press;
  logic [2:0] vote;
  state_t     state;

  assign btn = {i_btn_3, i_btn_2, i_btn_1};

  // Two-flop synchronizer; the raw buttons are fully asynchronous.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  end

  // The debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db      <= '0;
      db_prev <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      db_prev <= db;
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] != db[i]) begin
          if (cnt[i] + 8'd1 == DB_LIMIT) begin
            db[i]  <= ~db[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 8'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign press        = db & ~db_prev;
  assign multi        = (db[0] & db[1]) | (db[0] & db[2]) | (db[1] & db[2]);
  assign single_press = (press != 3'b000) && ((press & (press - 3'd1)) == 3'b000);

  // Ballot FSM; closing the poll overrides whatever this edge would otherwise do.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      vote         <= '0;
      o_reject     <= 1'b0;
      o_ready      <= 1'b0;
      o_closed     <= 1'b0;
      o_votes_cast <= '0;
    end else begin
      vote     <= '0;
      o_reject <= 1'b0;
      if (i_voting_over) begin
        state    <= CLOSED;
        o_ready  <= 1'b0;
        o_closed <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (i_ballot) begin
              state   <= ARMED;
              o_ready <= 1'b1;
            end
          end
          ARMED: begin
            if (press != 3'b000) begin
              o_ready <= 1'b0;
              if (single_press && !multi) begin
                vote         <= press;
                o_votes_cast <= o_votes_cast + 32'd1;
                state        <= VOTED;
              end else begin
                o_reject <= 1'b1;
                state    <= REJECT;
              end
            end
          end
          VOTED: begin
            if (db == 3'b000) state <= IDLE;
          end
          REJECT: begin
            if (db == 3'b000) begin
              state   <= ARMED;
              o_ready <= 1'b1;
            end
          end
          CLOSED: begin
            o_closed <= 1'b1;
          end
          default: begin
            state   <= IDLE;
            o_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_vote_1 = vote[0];
  assign o_vote_2 = vote[1];
  assign o_vote_3 = vote[2];

endmodule

// File: tb/tb_ballot_unit.sv
// Self-checking bench for ballot_unit: directed scenarios with fixed expectations
// plus a randomized run compared cycle by cycle against a behavioural model.
module tb_ballot_unit;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  btn = '0;
  logic        ballot = 1'b0;
  logic        over = 1'b0;
  logic        vote_1, vote_2, vote_3;
  logic        reject, ready, closed;
  logic [31:0] votes_cast;
  logic [2:0]  vote;

  int passed = 0;
  int total  = 0;

  assign vote = {vote_3, vote_2, vote_1};

  ballot_unit #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_btn_1      (btn[0]),
    .i_btn_2      (btn[1]),
    .i_btn_3      (btn[2]),
    .i_ballot     (ballot),
    .i_voting_over(over),
    .o_vote_1     (vote_1),
    .o_vote_2     (vote_2),
    .o_vote_3     (vote_3),
    .o_reject     (reject),
    .o_ready      (ready),
    .o_closed     (closed),
    .o_votes_cast (votes_cast)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, limit reached");
    $fatal(1, "watchdog expired");
  end

  // Behavioural model: button history is kept raw, and a debounced level is
  // taken to flip once the last DB synchronized samples all disagree with it.
  bit          hist [3][$];
  int          k_edge;
  bit [2:0]    m_db, m_db_prev;
  bit          m_open, m_wait_vote, m_wait_reject, m_closed;
  bit [2:0]    m_vote;
  bit          m_reject;
  int unsigned m_count;

  function automatic bit s_at(int b, int j);
    if (j < 2) return 1'b0;
    return hist[b][j-2];
  endfunction

  function automatic bit flip_due(int b, bit cur, int k);
    if (k - DB + 1 < 0) return 1'b0;
    for (int j = k - DB + 1; j <= k; j++)
      if (s_at(b, j) == cur) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 3; b++) hist[b].delete();
    k_edge = 0;
    m_db = '0; m_db_prev = '0;
    m_open = 0; m_wait_vote = 0; m_wait_reject = 0; m_closed = 0;
    m_vote = '0; m_reject = 0; m_count = 0;
  endtask

  task automatic model_edge();
    bit [2:0] pr;
    int np, nh;
    for (int b = 0; b < 3; b++) hist[b].push_back(btn[b]);
    pr = m_db & ~m_db_prev;
    np = $countones(pr);
    nh = $countones(m_db);
    m_vote = '0;
    m_reject = 0;
    if (over) begin
      m_closed = 1; m_open = 0; m_wait_vote = 0; m_wait_reject = 0;
    end else if (m_closed) begin
      m_closed = 1;
    end else if (m_wait_vote) begin
      if (nh == 0) m_wait_vote = 0;
    end else if (m_wait_reject) begin
      if (nh == 0) begin m_wait_reject = 0; m_open = 1; end
    end else if (m_open) begin
      if (np > 0) begin
        m_open = 0;
        if (np == 1 && nh < 2) begin
          m_vote = pr; m_count = m_count + 1; m_wait_vote = 1;
        end else begin
          m_reject = 1; m_wait_reject = 1;
        end
      end
    end else if (ballot) begin
      m_open = 1;
    end
    m_db_prev = m_db;
    for (int b = 0; b < 3; b++)
      if (flip_due(b, m_db[b], k_edge)) m_db[b] = ~m_db[b];
    k_edge++;
  endtask

  // One clock: model follows the edge, outputs are observed at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0; btn = '0; ballot = 1'b0; over = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic issue_ballot();
    ballot = 1'b1; tick(); ballot = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; btn = '0; ballot = 1'b0; over = 1'b0;
    model_reset();
    @(negedge clk);
    total++;
    if ({vote, reject, ready, closed} !== 6'b0) $display("FAIL reset_flags: got %b want 000000", {vote, reject, ready, closed});
    else passed++;
    total++;
    if (votes_cast !== 32'd0) $display("FAIL reset_count: got %0d want 0", votes_cast);
    else passed++;
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({vote, reject, ready, closed} !== 6'b0) $display("FAIL reset_idle: got %b want 000000", {vote, reject, ready, closed});
    else passed++;
  endtask

  task automatic test_clean_vote();
    int first_vote, pulses, n_ready;
    logic [2:0] vv;
    logic rdy_at_vote;
    apply_reset();
    issue_ballot();
    total++;
    if (ready !== 1'b1) $display("FAIL clean_armed: ready got %b want 1", ready);
    else passed++;
    btn = 3'b010; first_vote = 0; pulses = 0; vv = '0; rdy_at_vote = 1'bx;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (vote !== 3'b000) begin
        pulses++;
        if (first_vote == 0) begin first_vote = n; vv = vote; rdy_at_vote = ready; end
      end
    end
    total++;
    if (first_vote !== DB + 3) $display("FAIL clean_latency: pulse at edge %0d want %0d", first_vote, DB + 3);
    else passed++;
    total++;
    if (pulses !== 1 || vv !== 3'b010) $display("FAIL clean_pulse: %0d pulses vote=%b want 1 pulse 010", pulses, vv);
    else passed++;
    total++;
    if (rdy_at_vote !== 1'b0) $display("FAIL clean_ready_drop: ready at vote %b want 0", rdy_at_vote);
    else passed++;
    total++;
    if (votes_cast !== 32'd1) $display("FAIL clean_count: got %0d want 1", votes_cast);
    else passed++;
    // Release with the ballot held: back to IDLE DB+2 edges later, re-armed one edge after.
    btn = 3'b000; ballot = 1'b1; n_ready = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (ready === 1'b1 && n_ready == 0) n_ready = n;
    end
    ballot = 1'b0;
    total++;
    if (n_ready !== DB + 4) $display("FAIL clean_release_rearm: ready at edge %0d want %0d", n_ready, DB + 4);
    else passed++;
  endtask

  task automatic test_bounce();
    int early, pulses;
    logic [2:0] vv;
    apply_reset();
    issue_ballot();
    early = 0; pulses = 0; vv = '0;
    for (int n = 1; n <= 6; n++) begin
      btn[0] = n[0];
      tick();
      if (vote !== 3'b000 || reject !== 1'b0) early++;
    end
    btn[0] = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (vote !== 3'b000) begin pulses++; vv = vote; end
      if (reject !== 1'b0) early++;
    end
    total++;
    if (early !== 0) $display("FAIL bounce_quiet: %0d stray pulses want 0", early);
    else passed++;
    total++;
    if (pulses !== 1 || vv !== 3'b001) $display("FAIL bounce_vote: %0d pulses vote=%b want 1 pulse 001", pulses, vv);
    else passed++;
    btn = '0;
  endtask

  task automatic test_no_ballot();
    int pulses;
    apply_reset();
    btn = 3'b100; pulses = 0;
    for (int n = 1; n <= 12; n++) begin tick(); if (vote !== 3'b000 || reject !== 1'b0) pulses++; end
    total++;
    if (pulses !== 0 || votes_cast !== 32'd0) $display("FAIL idle_ignore: %0d pulses count=%0d want 0/0", pulses, votes_cast);
    else passed++;
    btn = 3'b000; repeat (8) tick();
    issue_ballot();
    btn = 3'b100; pulses = 0;
    for (int n = 1; n <= 12; n++) begin tick(); if (vote === 3'b100) pulses++; end
    total++;
    if (pulses !== 1) $display("FAIL ballot_vote3: got %0d pulses want 1", pulses);
    else passed++;
    btn = 3'b000; repeat (8) tick();
    btn = 3'b100; pulses = 0;
    for (int n = 1; n <= 12; n++) begin tick(); if (vote !== 3'b000) pulses++; end
    total++;
    if (pulses !== 0 || votes_cast !== 32'd1) $display("FAIL second_press: %0d pulses count=%0d want 0/1", pulses, votes_cast);
    else passed++;
    btn = '0;
  endtask

  task automatic test_ambiguous();
    int rejects, votes;
    logic [2:0] vv;
    apply_reset();
    issue_ballot();
    btn = 3'b011; rejects = 0; votes = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (reject === 1'b1) rejects++;
      if (vote !== 3'b000) votes++;
    end
    total++;
    if (rejects !== 1 || votes !== 0) $display("FAIL ambig_reject: rejects=%0d votes=%0d want 1/0", rejects, votes);
    else passed++;
    btn = 3'b000; repeat (8) tick();
    total++;
    if (ready !== 1'b1) $display("FAIL ambig_rearm: ready got %b want 1", ready);
    else passed++;
    btn = 3'b001; votes = 0; vv = '0;
    for (int n = 1; n <= 12; n++) begin tick(); if (vote !== 3'b000) begin votes++; vv = vote; end end
    total++;
    if (votes !== 1 || vv !== 3'b001 || votes_cast !== 32'd1) $display("FAIL ambig_then_vote: pulses=%0d vote=%b count=%0d want 1/001/1", votes, vv, votes_cast);
    else passed++;
    btn = '0;
  endtask

  task automatic test_close_priority();
    int pulses;
    apply_reset();
    issue_ballot();
    btn = 3'b010;
    for (int n = 1; n <= DB + 2; n++) tick();
    over = 1'b1;
    tick();
    total++;
    if ({vote, reject, ready, closed} !== 6'b000001 || votes_cast !== 32'd0)
      $display("FAIL close_edge: flags=%b count=%0d want 000001/0", {vote, reject, ready, closed}, votes_cast);
    else passed++;
    over = 1'b0; btn = 3'b000;
    repeat (8) tick();
    issue_ballot();
    btn = 3'b100; pulses = 0;
    for (int n = 1; n <= 12; n++) begin tick(); if (vote !== 3'b000 || reject !== 1'b0 || ready !== 1'b0) pulses++; end
    total++;
    if (pulses !== 0 || closed !== 1'b1 || votes_cast !== 32'd0)
      $display("FAIL close_frozen: activity=%0d closed=%b count=%0d want 0/1/0", pulses, closed, votes_cast);
    else passed++;
    btn = '0;
  endtask

  task automatic test_async_reset();
    int found, pulses;
    apply_reset();
    issue_ballot();
    btn = 3'b001; found = 0;
    for (int n = 1; n <= 20 && found == 0; n++) begin tick(); if (vote !== 3'b000) found = n; end
    total++;
    if (found == 0) $display("FAIL areset_pulse_seen: no vote within 20 edges, want one");
    else passed++;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({vote, reject, ready, closed} !== 6'b0 || votes_cast !== 32'd0)
      $display("FAIL areset_immediate: flags=%b count=%0d want 000000/0", {vote, reject, ready, closed}, votes_cast);
    else passed++;
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 10; n++) begin tick(); if (vote !== 3'b000 || ready !== 1'b0) pulses++; end
    issue_ballot();
    total++;
    if (pulses !== 0 || ready !== 1'b1 || votes_cast !== 32'd0)
      $display("FAIL areset_idle: activity=%0d ready=%b count=%0d want 0/1/0", pulses, ready, votes_cast);
    else passed++;
    pulses = 0;
    for (int n = 1; n <= 10; n++) begin tick(); if (vote !== 3'b000) pulses++; end
    total++;
    if (pulses !== 0) $display("FAIL held_button_no_vote: got %0d pulses want 0", pulses);
    else passed++;
    btn = '0;
  endtask

  task automatic test_random();
    int rem [3];
    logic [37:0] got, exp;
    apply_reset();
    for (int b = 0; b < 3; b++) rem[b] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          if ($urandom_range(0, 4) == 0) begin
            btn[b] = ~btn[b];
            rem[b] = $urandom_range(1, DB - 1);
          end else begin
            btn[b] = ($urandom_range(0, 2) == 0);
            rem[b] = $urandom_range(3, 25);
          end
        end else begin
          rem[b]--;
        end
      end
      ballot = ($urandom_range(0, 7) == 0);
      over   = (cyc >= 1400) && ($urandom_range(0, 15) == 0);
      tick();
      got = {vote, reject, ready, closed, votes_cast};
      exp = {m_vote, m_reject, m_open, m_closed, m_count};
      total++;
      if (got !== exp) $display("FAIL random_cycle %0d: got %h want %h", cyc, got, exp);
      else passed++;
    end
    btn = '0; ballot = 1'b0; over = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_vote();
    test_bounce();
    test_no_ballot();
    test_ambiguous();
    test_close_priority();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ballot_unit.md
# ballot_unit

Front-end ballot controller that sits directly upstream of `voting_machine`. It synchronizes and debounces the three raw candidate push-buttons and enforces one vote per ballot issued by the presiding officer. For each accepted vote it produces a single-cycle, clean `o_vote_n` pulse that drives the matching `i_candidate_n` input of `voting_machine`. Ambiguous multi-button presses are rejected, and all voting is frozen once polling closes.

## Interface
- `DEBOUNCE_CYCLES`, default 4: number of consecutive clock edges a synchronized button must disagree with its debounced level before that level flips. Legal range is 2..255.
- `clk`  in  1: system clock, rising-edge.
- `rst`  in  1: reset, asynchronous, active-low. While low, all state clears immediately.
- `i_btn_1`, `i_btn_2`, `i_btn_3`  in  1 each: raw, asynchronous, bouncing candidate buttons. High means pressed.
- `i_ballot`  in  1: officer issues a ballot. Level, sampled only in IDLE.
- `i_voting_over`  in  1: polling closed. Level, highest priority.
- `o_vote_1`, `o_vote_2`, `o_vote_3`  out  1 each: one-cycle accepted-vote pulses, at most one high per cycle.
- `o_reject`  out  1: one-cycle pulse on an ambiguous press.
- `o_ready`  out  1: high while in ARMED (ballot open).
- `o_closed`  out  1: high while in CLOSED.
- `o_votes_cast`  out  32: count of accepted votes, wraps modulo 2^32.

## Operation
- **Synchronizer:** each `i_btn_n` passes through a 2-flop synchronizer; the second flop is `s_n`.
- **Debouncer (per button):** 8-bit counter `cnt_n` and level `db_n`.
  - If `s_n != db_n`, increment `cnt_n`. When the count would reach `DEBOUNCE_CYCLES`, toggle `db_n` and clear `cnt_n`.
  - If `s_n == db_n`, clear `cnt_n`.
- **Press event:** `press_n` = `db_n` high and its previous-cycle value low.
- **Multiple held:** `multi` = two or more of `db_1..3` high.
- **States:** IDLE, ARMED, VOTED, REJECT, CLOSED.
- **IDLE:**
  - `i_ballot` high → ARMED.
  - Presses are ignored.
- **ARMED:** on any press event:
  - If exactly one press event occurs and `multi` is low → register `o_vote_n` = 1, increment `o_votes_cast`, go to VOTED.
  - Otherwise (`multi` high, or two or more press events) → register `o_reject` = 1, go to REJECT.
- **VOTED:**
  - When all `db_n` are low → IDLE.
  - Further presses are ignored.
- **REJECT:**
  - When all `db_n` are low → ARMED.
  - No further `o_reject` pulses are produced in this state.
- **CLOSED:** terminal state; only `rst` leaves it. Buttons and `i_ballot` are ignored.
- **`i_voting_over` priority:** if sampled high in any state → CLOSED at that edge. That edge produces no vote, no reject, and no counter change.
- **Ballot while a button is held:** a button already held when the ballot is issued does not vote. Only a new debounced rising edge counts.
- **Debouncer activity:** debouncers run in every state, including CLOSED.

## Timing
- **Reset values:** all outputs 0, state IDLE, sync flops 0, `db_n` = 0, `cnt_n` = 0, `o_votes_cast` = 0.
- **Vote latency:** let E0 be the first edge sampling `i_btn_n` high while the input is held clean.
  - `db_n` rises at edge E0 + `DEBOUNCE_CYCLES` + 1.
  - `o_vote_n` is registered at edge E0 + `DEBOUNCE_CYCLES` + 2 and is high for exactly one cycle.
- **Reject pulse:** `o_reject` uses the same timing as a vote pulse.
- **Counter update:** `o_votes_cast` updates on the same edge that `o_vote_n` is registered.
- **`o_ready`:** high from the edge entering ARMED to the edge leaving it.
- **`o_closed`:** high from the edge entering CLOSED.
- **Glitch rejection:** a glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles never changes `db_n`.
- **Release:** release is debounced identically, so VOTED → IDLE occurs `DEBOUNCE_CYCLES` + 2 edges after a clean release.
- **Reset during operation:** asserting `rst` mid-pulse drops `o_vote_n` immediately. A press interrupted by reset is not replayed after reset.
- **Ballot sampling:** `i_ballot` held high across VOTED → IDLE re-arms on the next edge. The officer must pulse `i_ballot` for a single ballot.

## Test plan
- **Clean vote:** `DEBOUNCE_CYCLES` = 4. Reset, pulse `i_ballot`, hold `i_btn_2` high for 100 ns (10 cycles) → one `o_vote_2` pulse exactly 6 edges after first sample, `o_votes_cast` = 1, `o_ready` drops on the same edge, then IDLE after release.
- **Bounce:** toggle `i_btn_1` every cycle for 6 cycles, then hold high → exactly one `o_vote_1` pulse; no pulse during bouncing.
- **No ballot / second press:** press `i_btn_3` in IDLE → no pulse. Issue a ballot, vote 3, press 3 again before the next ballot → `o_votes_cast` = 1 only.
- **Ambiguous press:** in ARMED, hold `i_btn_1` and `i_btn_2` together → one `o_reject` pulse, no vote. Release both, then press `i_btn_1` → `o_vote_1`, count = 1.
- **Close priority:** assert `i_voting_over` on the edge where a vote would register → no pulse, `o_closed` = 1, count unchanged. Later presses and ballots are ignored.
- **Async reset:** pull `rst` low mid-pulse, between clock edges → all outputs 0 immediately. After release, the module is in IDLE and `o_votes_cast` = 0.
